// File: rtl/corescore_stream_arbiter.sv
// corescore_stream_arbiter
//   Packet-granular round-robin arbiter. NUM_SOURCES byte streams
//   (tdata/tlast/tvalid/tready) share one downstream consumer. A grant is held
//   from the first beat through the tlast beat, so messages never interleave.
//   A stall watchdog reclaims the grant from a source that stops mid-packet.
//
// Ports
//   i_clk, i_rst_n           clock (rising edge), synchronous active-low reset
//   i_tdata/i_tlast/i_tvalid per-source stream inputs (source s byte on [8*s+7:8*s])
//   o_tready                 per-source ready, only the granted bit can be 1
//   o_tdata/o_tlast/o_tvalid muxed stream to the consumer
//   i_tready                 consumer ready
//   o_grant                  one-hot registered grant, 0 when idle
//   o_timeout                one-cycle pulse when the watchdog revokes a grant
module corescore_stream_arbiter #(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [8*NUM_SOURCES-1:0] i_tdata,
  input  logic [NUM_SOURCES-1:0]   i_tlast,
  input  logic [NUM_SOURCES-1:0]   i_tvalid,
  output logic [NUM_SOURCES-1:0]   o_tready,
  output logic [7:0]               o_tdata,
  output logic                     o_tlast,
  output logic                     o_tvalid,
  input  logic                     i_tready,
  output logic [NUM_SOURCES-1:0]   o_grant,
  output logic                     o_timeout
);

  localparam int unsigned PW = $clog2(NUM_SOURCES);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT);
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_SOURCES - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  // Round-robin pick: first requester scanning ptr+1, ptr+2, ... with wrap.
  logic          found;
  logic [PW-1:0] pick;

  always_comb begin
    int unsigned idx;
    logic [PW-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    pick  = ptr_q;
    for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
      idx  = (32'(ptr_q) + i) % NUM_SOURCES;
      cand = PW'(idx);
      if (!found && i_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // While LOCKED the pointer always equals the granted source, so it doubles
  // as the mux select.
  logic sel_valid;
  logic sel_last;
  assign sel_valid = i_tvalid[ptr_q];
  assign sel_last  = i_tlast[ptr_q];

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PTR_RST;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d       = LOCKED;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          ptr_d         = pick;
        end
      end
      LOCKED: begin
        if (sel_valid && i_tready && sel_last) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (TIMEOUT > 0) begin
          // Only missing tvalid counts as a stall; consumer backpressure does not.
          if (sel_valid) begin
            cnt_d = '0;
          end else if (cnt_q + CW'(1) == TMAX) begin
            // Pointer stays on the stalled source so it gets lowest priority next.
            timeout_d = 1'b1;
            state_d   = IDLE;
            grant_d   = '0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output logic: combinational data path from the granted source
  always_comb begin
    o_grant   = grant_q;
    o_timeout = timeout_q;
    o_tready  = '0;
    o_tdata   = '0;
    o_tlast   = 1'b0;
    o_tvalid  = 1'b0;
    if (state_q == LOCKED) begin
      o_tdata         = i_tdata[{ptr_q, 3'b000} +: 8];
      o_tlast         = sel_last;
      o_tvalid        = sel_valid;
      o_tready[ptr_q] = i_tready;
    end
  end

endmodule
